// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory request at a time, with a small
// FIFO of {instr, pc, pc+1} entries feeding decode. A flush discards queued and in-flight work.
module fetch_queue #(
  parameter int PC_WIDTH    = 24,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic [PC_WIDTH-1:0]    pcplus1_in,
  input  logic                   flush,
  output logic                   fetch_enable,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   decode_ready,
  output logic                   decode_valid,
  output logic [INSTR_WIDTH-1:0] decode_instr,
  output logic [PC_WIDTH-1:0]    decode_pc,
  output logic [PC_WIDTH-1:0]    decode_pcplus1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [PC_WIDTH-1:0]  r_req_pc;
  logic [PC_WIDTH-1:0]  r_req_pcp1;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [PC_WIDTH-1:0]    r_mem_pc    [DEPTH];
  logic [PC_WIDTH-1:0]    r_mem_pcp1  [DEPTH];

  logic w_not_full;
  logic w_issue;
  logic w_push;
  logic w_pop;

  assign w_not_full = (r_count < CNT_W'(DEPTH));
  assign w_issue    = (r_state == S_IDLE) && w_not_full && !flush;
  assign w_push     = (r_state == S_WAIT) && imem_ack && !flush;
  assign w_pop      = (r_count != '0) && decode_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_issue) w_next = S_WAIT;
      S_WAIT: begin
        if (imem_ack)   w_next = S_IDLE;
        else if (flush) w_next = S_DROP;
      end
      // The abandoned request must still complete on the bus before a new one issues.
      S_DROP: if (imem_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req_pc   <= '0;
      r_req_pcp1 <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_req_pc   <= pc_in;
        r_req_pcp1 <= pcplus1_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_instr[r_tail] <= imem_rdata;
      r_mem_pc[r_tail]    <= r_req_pc;
      r_mem_pcp1[r_tail]  <= r_req_pcp1;
    end
  end

  assign fetch_enable   = reset && (w_issue || flush);
  assign imem_req       = (r_state != S_IDLE);
  assign imem_addr      = r_req_pc;
  assign decode_valid   = (r_count != '0);
  assign decode_instr   = decode_valid ? r_mem_instr[r_head] : '0;
  assign decode_pc      = decode_valid ? r_mem_pc[r_head]    : '0;
  assign decode_pcplus1 = decode_valid ? r_mem_pcp1[r_head]  : '0;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_WIDTH, default 24: width of every PC field.
REQ-002 Parameter INSTR_WIDTH, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 pc_in  in  PC_WIDTH  current PC from the fetch stage.
REQ-007 pcplus1_in  in  PC_WIDTH  PC+1 from the fetch stage.
REQ-008 flush  in  1  redirect (branch taken); discard all queued and in-flight instructions.
REQ-009 fetch_enable  out  1  drives the fetch stage PC register enable.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  PC_WIDTH  instruction memory address.
REQ-012 imem_ack  in  1  memory response valid; imem_rdata is valid this cycle.
REQ-013 imem_rdata  in  INSTR_WIDTH  instruction word.
REQ-014 decode_ready  in  1  decode stage accepts the head entry this cycle.
REQ-015 decode_valid  out  1  head entry valid.
REQ-016 decode_instr / decode_pc / decode_pcplus1  out  INSTR_WIDTH / PC_WIDTH / PC_WIDTH  head entry fields.

Function
REQ-017 FSM states: IDLE, WAIT, DROP; exactly one request outstanding at most.
REQ-018 IDLE, flush=0, count<DEPTH: at the edge, capture pc_in/pcplus1_in into request registers, go WAIT.
REQ-019 IDLE, count==DEPTH: stay IDLE, issue nothing.
REQ-020 fetch_enable = (state==IDLE && count<DEPTH && !flush) || flush; forced 0 while reset is asserted.
REQ-021 imem_req = 1 iff state is WAIT or DROP; imem_addr = captured PC, held stable until imem_ack.
REQ-022 WAIT, imem_ack=1, flush=0: push {imem_rdata, captured pc, captured pcplus1} at tail, go IDLE.
REQ-023 WAIT, imem_ack=0, flush=1: go DROP.
REQ-024 WAIT, imem_ack=1, flush=1: discard response, go IDLE.
REQ-025 DROP: imem_req stays 1; on imem_ack, discard data, go IDLE; flush in DROP keeps DROP.
REQ-026 imem_ack in IDLE is ignored.
REQ-027 Latency: single-cycle memory (ack in first WAIT cycle) gives decode_valid 2 cycles after pc_in is captured; peak throughput 1 entry per 2 cycles.
REQ-028 decode_valid = (count != 0); decode_* show head entry combinationally from registered storage.
REQ-029 Pop when decode_valid && decode_ready; decode_ready on an empty queue has no effect.
REQ-030 Simultaneous push and pop: count unchanged, head advances, tail advances.
REQ-031 Push when count==DEPTH cannot occur (issue gated by REQ-019); pop in the same cycle as a push at count==DEPTH-1 leaves count at DEPTH-1.
REQ-032 Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
REQ-033 flush has priority over push and pop: count, head, and tail all go to 0 at the edge; decode_valid is 0 the next cycle.

Reset
REQ-034 When reset=0, immediately: state=IDLE, count=0, pointers=0, imem_req=0, imem_addr=0, decode_valid=0, decode_* =0, fetch_enable=0.
REQ-035 Reset asserted mid-request abandons it; a late imem_ack after reset release while in IDLE is ignored (REQ-026).
REQ-036 Storage array contents need no reset; decode_* read 0 whenever count==0.

Verification
REQ-037 Reset release, pc_in=0x000010, ack one cycle after req: imem_addr=0x000010; decode_valid=1 with decode_pc=0x000010, decode_pcplus1=0x000011, decode_instr=rdata.
REQ-038 decode_ready=0, 5 fetches at PC 0..4: queue holds PC 0..3; fetch_enable=0 and imem_req=0 with count=4; one pop -> request for PC 4 issued.
REQ-039 flush in a WAIT cycle without ack, ack 3 cycles later with 0xDEADBEEF: no entry pushed, decode_valid=0, FSM back in IDLE, next request uses the new pc_in.
REQ-040 flush and imem_ack in the same cycle with count=2: count=0 and response discarded next cycle.
REQ-041 Continuous decode_ready=1 over 10 fetches: 10 entries pop in PC order; pointers wrap twice; no entry lost or duplicated.
REQ-042 reset pulsed low in WAIT: outputs match REQ-034 asynchronously; a following stray ack creates no entry.
